// File: rtl/switch_event_encoder_if.sv
// Show-ahead event stream from the switch encoder to its consumer.
// The master presents the head event and the slave acknowledges it with ev_ready.
interface switch_event_encoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_index;
  logic       ev_level;

  modport master (output ev_valid, ev_index, ev_level, input ev_ready);
  modport slave  (input ev_valid, ev_index, ev_level, output ev_ready);
endinterface

// File: rtl/switch_event_encoder.sv
// Ten slide switches: synchronize, debounce, and queue each accepted level change
// as an {index, level} event in a small show-ahead FIFO.
module switch_event_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [9:0]                   sw,
  switch_event_encoder_if.master       ev,
  output logic [9:0]                   stable_sw,
  output logic                         overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = PW + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [OW-1:0] OCC_FULL  = OW'(FIFO_DEPTH);

  logic [9:0]    sync1_reg, sync2_reg;
  logic [CW-1:0] cnt_reg [10];
  logic [9:0]    stable_reg;
  logic [9:0]    pending_reg, pend_level_reg;
  logic          overflow_reg;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [OW-1:0] count_reg;

  logic [9:0]    hit, push_mask, lost;
  logic          sel_valid;
  logic [3:0]    sel_idx;
  logic          pop, can_push, push;
  logic [4:0]    head;

  // A switch is accepted on the edge that would complete DEBOUNCE_CYCLES mismatches.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_hit
      assign hit[gi] = (sync2_reg[gi] != stable_reg[gi]) && (cnt_reg[gi] == CNT_LAST);
    end
  endgenerate

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (pending_reg[i]) begin
        sel_valid = 1'b1;
        sel_idx   = 4'(i);
      end
    end
  end

  assign pop       = (count_reg != '0) && ev.ev_ready;
  assign can_push  = (count_reg < OCC_FULL) || pop;
  assign push      = sel_valid && can_push;
  assign push_mask = push ? (10'b1 << sel_idx) : 10'b0;
  // A re-debounce only loses an event if the older one is not leaving this very edge.
  assign lost      = hit & pending_reg & ~push_mask;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      stable_reg     <= '0;
      pending_reg    <= '0;
      pend_level_reg <= '0;
      overflow_reg   <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      for (int i = 0; i < 10; i++) cnt_reg[i] <= '0;
    end else begin
      sync1_reg <= sw;
      sync2_reg <= sync1_reg;
      for (int i = 0; i < 10; i++) begin
        if (sync2_reg[i] != stable_reg[i]) begin
          if (cnt_reg[i] == CNT_LAST) begin
            stable_reg[i] <= sync2_reg[i];
            cnt_reg[i]    <= '0;
          end else begin
            cnt_reg[i] <= cnt_reg[i] + 1'b1;
          end
        end else begin
          cnt_reg[i] <= '0;
        end
      end
      pending_reg    <= (pending_reg & ~push_mask) | hit;
      pend_level_reg <= (pend_level_reg & ~hit) | (sync2_reg & hit);
      overflow_reg   <= overflow_reg | (|lost);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Event storage carries no reset so it can map onto distributed/block memory.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= {sel_idx, pend_level_reg[sel_idx]};
  end

  assign head        = mem[rd_ptr_reg];
  assign ev.ev_valid = (count_reg != '0);
  assign ev.ev_index = reset ? 4'd0 : head[4:1];
  assign ev.ev_level = reset ? 1'b0 : head[0];
  assign stable_sw   = stable_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_switch_event_encoder.sv
// Directed bench for switch_event_encoder with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4;
// a cycle model of the switch rules is checked every cycle alongside literal expectations.
module tb_switch_event_encoder;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sw    = '0;
  logic [9:0] stable_sw;
  logic       overflow;

  switch_event_encoder_if ev();

  switch_event_encoder #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .sw        (sw),
    .ev        (ev),
    .stable_sw (stable_sw),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: switch state as seen two samples late, run lengths of disagreement,
  // a set of waiting switches and a plain queue of delivered-to-FIFO events.
  logic [9:0] m_s1, m_s2, m_stab, m_pend, m_plev;
  int         m_run [10];
  logic [4:0] m_q [$];
  bit         m_ovf;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_stab = '0; m_pend = '0; m_plev = '0; m_ovf = 1'b0;
    for (int i = 0; i < 10; i++) m_run[i] = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit         pop, accept;
    int         pick;
    logic [3:0] pi;
    pop    = (m_q.size() != 0) && ev.ev_ready;
    accept = (m_q.size() < DEPTH) || pop;
    pick   = -1;
    if (accept)
      for (int i = 9; i >= 0; i--) if (m_pend[i]) pick = i;
    if (pop) void'(m_q.pop_front());
    if (pick >= 0) begin
      pi = 4'(pick);
      m_q.push_back({pi, m_plev[pick]});
      m_pend[pick] = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (m_s2[i] != m_stab[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          m_stab[i] = m_s2[i];
          m_run[i]  = 0;
          if (m_pend[i]) m_ovf = 1'b1;
          m_pend[i] = 1'b1;
          m_plev[i] = m_s2[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_clear();
      else       model_step();
    end
  end

  initial begin
    logic       exp_valid;
    logic [4:0] h;
    forever begin
      @(negedge clock);
      exp_valid = (m_q.size() != 0);
      check("ev_valid", ev.ev_valid, exp_valid);
      check("stable_sw", stable_sw, m_stab);
      check("overflow", overflow, m_ovf);
      if (reset) begin
        check("ev_index_in_reset", ev.ev_index, 0);
        check("ev_level_in_reset", ev.ev_level, 0);
      end else if (exp_valid) begin
        h = m_q[0];
        check("ev_index", ev.ev_index, h[4:1]);
        check("ev_level", ev.ev_level, h[0]);
        if (ev.ev_ready) $display("event index %0d level %0d", ev.ev_index, ev.ev_level);
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic at_negedge();
    @(negedge clock);
    #1;
  endtask

  initial begin
    ev.ev_ready = 1'b0;
    edges(3);
    check("rst_valid", ev.ev_valid, 0);
    check("rst_index", ev.ev_index, 0);
    check("rst_level", ev.ev_level, 0);
    check("rst_stable", stable_sw, 0);
    check("rst_overflow", overflow, 0);
    at_negedge();
    reset = 1'b0;

    // Clean single transition with a consumer that is always ready.
    ev.ev_ready = 1'b1;
    at_negedge();
    sw[3] = 1'b1;
    edges(5);  check("s1_stable_e5", stable_sw, 10'h000);
    edges(1);  check("s1_stable_e6", stable_sw, 10'h008);
               check("s1_valid_e6", ev.ev_valid, 0);
    edges(1);  check("s1_valid_e7", ev.ev_valid, 1);
               check("s1_index_e7", ev.ev_index, 3);
               check("s1_level_e7", ev.ev_level, 1);
    edges(1);  check("s1_valid_e8", ev.ev_valid, 0);

    // Glitch three samples long is rejected.
    at_negedge();
    sw[5] = 1'b1;
    edges(3);
    sw[5] = 1'b0;
    edges(10); check("s2_stable", stable_sw, 10'h008);
               check("s2_valid", ev.ev_valid, 0);

    // Simultaneous rise: ascending index order on consecutive cycles.
    at_negedge();
    sw = sw | 10'h085;
    edges(6);  check("s3_stable", stable_sw, 10'h08D);
               check("s3_valid_e6", ev.ev_valid, 0);
    edges(1);  check("s3_idx0", ev.ev_index, 0);
    edges(1);  check("s3_idx2", ev.ev_index, 2);
    edges(1);  check("s3_idx7", ev.ev_index, 7);
               check("s3_lvl7", ev.ev_level, 1);
    edges(1);  check("s3_valid_end", ev.ev_valid, 0);

    at_negedge();
    sw = '0;
    edges(20); check("idle_stable", stable_sw, 10'h000);
               check("idle_valid", ev.ev_valid, 0);

    // Backpressure: four queued, two held pending, then drained in order.
    ev.ev_ready = 1'b0;
    at_negedge();
    sw = 10'h03F;
    edges(12); check("s4_valid", ev.ev_valid, 1);
               check("s4_head", ev.ev_index, 0);
               check("s4_overflow", overflow, 0);
    at_negedge();
    ev.ev_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      edges(1); check("s4_drain_idx", ev.ev_index, k);
    end
    edges(1);  check("s4_drained", ev.ev_valid, 0);

    // Full FIFO, sw[9] changes twice while waiting: earlier event lost.
    ev.ev_ready = 1'b0;
    at_negedge();
    sw = 10'h030;
    edges(12); check("s5_head", ev.ev_index, 0);
               check("s5_head_lvl", ev.ev_level, 0);
    sw[9] = 1'b1;
    edges(8);  check("s5_stable_up", stable_sw, 10'h230);
               check("s5_ovf_before", overflow, 0);
    sw[9] = 1'b0;
    edges(8);  check("s5_stable_dn", stable_sw, 10'h030);
               check("s5_ovf_after", overflow, 1);
    at_negedge();
    ev.ev_ready = 1'b1;
    edges(1);  check("s5_idx1", ev.ev_index, 1);
    edges(3);  check("s5_idx9", ev.ev_index, 9);
               check("s5_lvl9", ev.ev_level, 0);
    edges(1);  check("s5_empty", ev.ev_valid, 0);
               check("s5_ovf_sticky", overflow, 1);

    // Reset while events are queued and a switch is mid-count.
    ev.ev_ready = 1'b0;
    at_negedge();
    sw = 10'h000;
    edges(10); check("s6_queued", ev.ev_valid, 1);
               check("s6_head", ev.ev_index, 4);
    sw[8] = 1'b1;
    edges(3);
    @(negedge clock);
    #2;
    reset = 1'b1;
    sw    = '0;
    #1;
    check("s6_rst_valid", ev.ev_valid, 0);
    check("s6_rst_index", ev.ev_index, 0);
    check("s6_rst_ovf", overflow, 0);
    check("s6_rst_stable", stable_sw, 0);
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    edges(20); check("s6_no_event", ev.ev_valid, 0);

    // Switch already high when reset releases.
    @(negedge clock);
    #2;
    reset = 1'b1;
    sw    = 10'h040;
    at_negedge();
    reset = 1'b0;
    edges(12); check("s7_valid", ev.ev_valid, 1);
               check("s7_index", ev.ev_index, 6);
               check("s7_level", ev.ev_level, 1);
               check("s7_stable", stable_sw, 10'h040);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
